vga_frame_streamer: RTL and testbench

// Parametrised Avalon-ST pixel source for the VGA output path. Emits one full frame of
// H_ACTIVE x V_ACTIVE pixels per packet: framed line-buffer pixels inside a column window,

---
 rtl/vga_frame_streamer.sv | 153 +++++++++++++++
 tb/tb_vga_frame_streamer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_streamer.sv
// Avalon-ST frame source: one H_ACTIVE x V_ACTIVE packet per frame built from a line buffer,
// optional border columns or colour bars, with ready/valid backpressure and prefetch pulses.
module vga_frame_streamer #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int X_START    = 80,
   parameter int X_END      = 560,
   parameter int BORDER_EN  = 1,
   parameter int IN_BITS    = 8,
   parameter int OUT_BITS   = 10,
   parameter int ADDR_W     = 9,
   parameter int ROW_LEAD   = 80,
   parameter int FRAME_LEAD = 1040
) (
   input  logic                    clock_vga,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    test_pattern,
   input  logic [3*IN_BITS-1:0]    data,
   output logic [ADDR_W-1:0]       address,
   output logic [3*OUT_BITS-1:0]   src_data,
   output logic                    src_valid,
   input  logic                    src_ready,
   output logic                    src_sop,
   output logic                    src_eop,
   output logic                    next_row,
   output logic                    next_screen,
   output logic                    busy
);
   localparam int XW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int SCR_IDX = H_ACTIVE * V_ACTIVE - FRAME_LEAD;
   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
   localparam logic [XW-1:0] X_ROW  = XW'(H_ACTIVE - ROW_LEAD);
   localparam logic [XW-1:0] X_SCR  = XW'(SCR_IDX % H_ACTIVE);
   localparam logic [YW-1:0] Y_SCR  = YW'(SCR_IDX / H_ACTIVE);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                  state_reg, state_next;
   logic [XW-1:0]           x_reg, x_next;
   logic [YW-1:0]           y_reg, y_next;
   logic                    tp_reg;
   logic                    tp_cur;
   logic                    at_origin;
   logic                    load;
   logic                    accept;
   logic                    win_cur;
   logic                    border_cur;
   logic                    win_next;
   logic [ADDR_W-1:0]       addr_next;
   logic [2:0]              bar_inv;
   logic [3*OUT_BITS-1:0]   pixel;

   assign at_origin  = (x_reg == '0) && (y_reg == '0);
   assign accept     = src_valid && src_ready;
   assign tp_cur     = at_origin ? test_pattern : tp_reg;
   assign win_cur    = (int'(x_reg) >= X_START) && (int'(x_reg) <= X_END);
   assign border_cur = (BORDER_EN != 0) &&
                       ((int'(x_reg) == X_START - 1) || (int'(x_reg) == X_END + 1));
   assign win_next   = (int'(x_next) >= X_START) && (int'(x_next) <= X_END);
   assign addr_next  = win_next ? ADDR_W'(int'(x_next) - X_START) : '0;
   assign bar_inv    = 3'd7 - 3'((int'(x_reg) * 8) / H_ACTIVE);

   // A new frame is only started at the origin while enable is high; a frame already
   // under way always runs to its eop.
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      busy       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (enable)
               state_next = STREAM;
         end
         STREAM: begin
            busy = 1'b1;
            load = (!src_valid || src_ready) && !(at_origin && !enable);
            if (at_origin && !enable && (!src_valid || src_ready))
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      x_next = x_reg + 1'b1;
      y_next = y_reg;
      if (x_reg == X_LAST) begin
         x_next = '0;
         y_next = (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         logic [OUT_BITS-1:0] lb_chan;
         logic [OUT_BITS-1:0] chan;

         // Left-align the line-buffer channel; low bits are zero padding.
         assign lb_chan = OUT_BITS'(data[gi*IN_BITS +: IN_BITS]) << (OUT_BITS - IN_BITS);

         always_comb begin
            chan = '0;
            if (tp_cur)
               chan = {OUT_BITS{bar_inv[gi]}};
            else if (win_cur)
               chan = lb_chan;
            else if (border_cur)
               chan = '1;
         end

         assign pixel[gi*OUT_BITS +: OUT_BITS] = chan;
      end
   endgenerate

   always_ff @(posedge clock_vga) begin
      if (reset) begin
         state_reg   <= IDLE;
         x_reg       <= '0;
         y_reg       <= '0;
         tp_reg      <= 1'b0;
         address     <= '0;
         src_data    <= '0;
         src_valid   <= 1'b0;
         src_sop     <= 1'b0;
         src_eop     <= 1'b0;
         next_row    <= 1'b0;
         next_screen <= 1'b0;
      end else begin
         state_reg   <= state_next;
         next_row    <= load && (x_reg == X_ROW);
         next_screen <= load && (x_reg == X_SCR) && (y_reg == Y_SCR);
         if (state_reg == IDLE && enable)
            tp_reg <= test_pattern;
         if (load) begin
            src_data  <= pixel;
            src_valid <= 1'b1;
            src_sop   <= at_origin;
            src_eop   <= (x_reg == X_LAST) && (y_reg == Y_LAST);
            x_reg     <= x_next;
            y_reg     <= y_next;
            address   <= addr_next;
            if (at_origin)
               tp_reg <= test_pattern;
         end else if (accept) begin
            src_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_vga_frame_streamer.sv
// Directed bench for vga_frame_streamer on an 8x4 frame, window columns 2..5, with a
// second instance built without border columns.
module tb_vga_frame_streamer;
   logic        clock_vga = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        test_pattern = 1'b0;
   logic        src_ready = 1'b1;
   logic [23:0] data = 24'hFF8001;

   logic [1:0]  address, address_b;
   logic [29:0] src_data, src_data_b;
   logic        src_valid, src_sop, src_eop, next_row, next_screen, busy;
   logic        src_valid_b, src_sop_b, src_eop_b, next_row_b, next_screen_b, busy_b;

   int errors = 0;
   int checks = 0;

   logic [29:0] cap_data [64];
   logic [29:0] cap_data_b [64];
   logic        cap_sop [64];
   logic        cap_eop [64];
   int          cap_addr [64];
   int          nbeats, nrow, nscr, stall_bad;
   bit          timed_out;

   always #5 clock_vga = ~clock_vga;

   vga_frame_streamer #(
      .H_ACTIVE(8), .V_ACTIVE(4), .X_START(2), .X_END(5), .BORDER_EN(1),
      .IN_BITS(8), .OUT_BITS(10), .ADDR_W(2), .ROW_LEAD(2), .FRAME_LEAD(3)
   ) dut (
      .clock_vga(clock_vga), .reset(reset), .enable(enable), .test_pattern(test_pattern),
      .data(data), .address(address), .src_data(src_data), .src_valid(src_valid),
      .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop),
      .next_row(next_row), .next_screen(next_screen), .busy(busy)
   );

   vga_frame_streamer #(
      .H_ACTIVE(8), .V_ACTIVE(4), .X_START(2), .X_END(5), .BORDER_EN(0),
      .IN_BITS(8), .OUT_BITS(10), .ADDR_W(2), .ROW_LEAD(2), .FRAME_LEAD(3)
   ) dut_nb (
      .clock_vga(clock_vga), .reset(reset), .enable(enable), .test_pattern(test_pattern),
      .data(data), .address(address_b), .src_data(src_data_b), .src_valid(src_valid_b),
      .src_ready(src_ready), .src_sop(src_sop_b), .src_eop(src_eop_b),
      .next_row(next_row_b), .next_screen(next_screen_b), .busy(busy_b)
   );

   // Hand model of one pixel for the 8x4 configuration.
   function automatic logic [29:0] exp_px(input int xx, input bit tp, input bit border);
      logic [2:0] v;
      if (tp) begin
         v = 3'(7 - xx);
         return {{10{v[2]}}, {10{v[1]}}, {10{v[0]}}};
      end
      if (xx >= 2 && xx <= 5) return {10'h3FC, 10'h200, 10'h004};
      if (border && (xx == 1 || xx == 6)) return 30'h3FFF_FFFF;
      return 30'h0;
   endfunction

   // Records accepted beats until an eop is accepted; src_ready is chosen for the coming edge
   // before deciding whether the beat shown now is accepted or must be held.
   task automatic capture(input bit toggle, input int drop_at, input int flip_at);
      bit          held;
      logic [32:0] held_v;
      held = 1'b0;
      held_v = '0;
      nbeats = 0; nrow = 0; nscr = 0; stall_bad = 0; timed_out = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clock_vga);
         if (next_row) nrow++;
         if (next_screen) nscr++;
         if (held && ({src_valid, src_sop, src_eop, src_data} !== held_v)) stall_bad++;
         held = 1'b0;
         if (toggle) src_ready = ~src_ready;
         if (src_valid && src_ready) begin
            if (nbeats < 64) begin
               cap_data[nbeats]   = src_data;
               cap_data_b[nbeats] = src_data_b;
               cap_sop[nbeats]    = src_sop;
               cap_eop[nbeats]    = src_eop;
               cap_addr[nbeats]   = int'(address);
            end
            $display("beat %0d data=%h nb_data=%h sop=%b eop=%b addr=%0d",
                     nbeats, src_data, src_data_b, src_sop, src_eop, address);
            nbeats++;
            if (nbeats == drop_at) enable = 1'b0;
            if (nbeats == flip_at) test_pattern = ~test_pattern;
            if (src_eop) begin
               timed_out = 1'b0;
               break;
            end
         end else if (src_valid) begin
            held = 1'b1;
            held_v = {src_valid, src_sop, src_eop, src_data};
         end
      end
      src_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      enable = 1'b0;
      repeat (3) @(negedge clock_vga);
      checks++;
      if ({src_valid, src_sop, src_eop, next_row, next_screen, busy} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {src_valid, src_sop, src_eop, next_row, next_screen, busy});
      end
      checks++;
      if (src_data !== 30'h0) begin
         errors++; $display("FAIL reset_data: got %h expected 0", src_data);
      end
      checks++;
      if (address !== 2'd0) begin
         errors++; $display("FAIL reset_address: got %0d expected 0", address);
      end
      reset = 1'b0;
      repeat (3) @(negedge clock_vga);
      checks++;
      if (src_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL idle_no_enable: valid=%b busy=%b expected 0 0", src_valid, busy);
      end
   endtask

   task automatic test_stream();
      int xx, ea;
      enable = 1'b1;
      capture(1'b0, 0, 0);
      checks++;
      if (timed_out || nbeats != 32) begin
         errors++; $display("FAIL stream_beats: got %0d timeout=%b expected 32", nbeats, timed_out);
      end
      for (int k = 0; k < 32; k++) begin
         xx = k % 8;
         ea = (((k + 1) % 8) >= 2 && ((k + 1) % 8) <= 5) ? ((k + 1) % 8) - 2 : 0;
         checks++;
         if (cap_data[k] !== exp_px(xx, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL stream_data beat %0d: got %h expected %h", k, cap_data[k], exp_px(xx, 1'b0, 1'b1));
         end
         checks++;
         if (cap_data_b[k] !== exp_px(xx, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL noborder_data beat %0d: got %h expected %h", k, cap_data_b[k], exp_px(xx, 1'b0, 1'b0));
         end
         checks++;
         if (cap_sop[k] !== (k == 0) || cap_eop[k] !== (k == 31)) begin
            errors++;
            $display("FAIL stream_sop_eop beat %0d: got %b%b expected %b%b", k, cap_sop[k], cap_eop[k], k == 0, k == 31);
         end
         checks++;
         if (cap_addr[k] != ea) begin
            errors++; $display("FAIL stream_address beat %0d: got %0d expected %0d", k, cap_addr[k], ea);
         end
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL stream_busy: got %b expected 1", busy);
      end
   endtask

   task automatic test_backpressure();
      capture(1'b1, 0, 0);
      checks++;
      if (timed_out || nbeats != 32) begin
         errors++; $display("FAIL bp_beats: got %0d timeout=%b expected 32", nbeats, timed_out);
      end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (cap_data[k] !== exp_px(k % 8, 1'b0, 1'b1) || cap_sop[k] !== (k == 0) || cap_eop[k] !== (k == 31)) begin
            errors++;
            $display("FAIL bp_beat %0d: got %h sop=%b eop=%b expected %h", k, cap_data[k], cap_sop[k], cap_eop[k], exp_px(k % 8, 1'b0, 1'b1));
         end
      end
      checks++;
      if (stall_bad != 0) begin
         errors++; $display("FAIL bp_stall_hold: got %0d changed stalls expected 0", stall_bad);
      end
      checks++;
      if (nrow != 4) begin
         errors++; $display("FAIL bp_next_row: got %0d pulses expected 4", nrow);
      end
      checks++;
      if (nscr != 1) begin
         errors++; $display("FAIL bp_next_screen: got %0d pulses expected 1", nscr);
      end
   endtask

   task automatic test_enable_drop();
      capture(1'b0, 10, 0);
      checks++;
      if (timed_out || nbeats != 32 || cap_eop[31] !== 1'b1) begin
         errors++; $display("FAIL drop_complete: got %0d beats timeout=%b expected 32 ending in eop", nbeats, timed_out);
      end
      @(negedge clock_vga);
      checks++;
      if (src_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL drop_idle: valid=%b busy=%b expected 0 0", src_valid, busy);
      end
      repeat (4) @(negedge clock_vga);
      checks++;
      if (src_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL drop_stays_idle: valid=%b busy=%b expected 0 0", src_valid, busy);
      end
      enable = 1'b1;
      capture(1'b0, 20, 0);
      checks++;
      if (timed_out || nbeats != 32 || cap_sop[0] !== 1'b1 || cap_data[1] !== 30'h3FFF_FFFF) begin
         errors++;
         $display("FAIL reenable_frame: got %0d beats sop0=%b data1=%h expected 32 1 3fffffff", nbeats, cap_sop[0], cap_data[1]);
      end
      @(negedge clock_vga);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reenable_stop: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_pattern_bars();
      test_pattern = 1'b1;
      enable = 1'b1;
      capture(1'b0, 0, 12);
      checks++;
      if (timed_out || nbeats != 32) begin
         errors++; $display("FAIL bars_beats: got %0d timeout=%b expected 32", nbeats, timed_out);
      end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (cap_data[k] !== exp_px(k % 8, 1'b1, 1'b1) || cap_data_b[k] !== exp_px(k % 8, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL bars_data beat %0d: got %h/%h expected %h", k, cap_data[k], cap_data_b[k], exp_px(k % 8, 1'b1, 1'b1));
         end
      end
      capture(1'b0, 0, 0);
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (cap_data[k] !== exp_px(k % 8, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL bars_next_frame beat %0d: got %h expected %h", k, cap_data[k], exp_px(k % 8, 1'b0, 1'b1));
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      bit hit;
      n = 0;
      hit = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(negedge clock_vga);
         if (src_valid && src_ready) begin
            n++;
            if (n == 13) begin
               hit = 1'b1;
               break;
            end
         end
      end
      checks++;
      if (!hit) begin
         errors++; $display("FAIL midreset_reach: got %0d beats expected 13", n);
      end
      @(negedge clock_vga);
      src_ready = 1'b0;
      reset = 1'b1;
      @(negedge clock_vga);
      checks++;
      if (src_valid !== 1'b0 || address !== 2'd0 || busy !== 1'b0 || src_sop !== 1'b0) begin
         errors++;
         $display("FAIL midreset_state: valid=%b addr=%0d busy=%b sop=%b expected 0 0 0 0", src_valid, address, busy, src_sop);
      end
      reset = 1'b0;
      src_ready = 1'b1;
      capture(1'b0, 0, 0);
      checks++;
      if (timed_out || nbeats != 32 || cap_sop[0] !== 1'b1) begin
         errors++; $display("FAIL midreset_restart: got %0d beats sop0=%b expected 32 1", nbeats, cap_sop[0]);
      end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (cap_data[k] !== exp_px(k % 8, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL midreset_data beat %0d: got %h expected %h", k, cap_data[k], exp_px(k % 8, 1'b0, 1'b1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_enable_drop();
      test_pattern_bars();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
